maxpool_stream: RTL
===================

// Module: maxpool_stream
// PURPOSE
//  Streaming POOLxPOOL max-pool (stride POOL) over a raster-order feature map, one pixel per valid beat.
//  Generalises the 2x2 valid-gating pooling logic with a real datapath: it computes the maxima rather than only gating valid.
//  Also adds a configurable window, multiple channels, signed/unsigned compare and frame resync.
//  Sits between a conv/ReLU stage and the next conv layer's input FIFO.
// PARAMETERS
//  DATA_W   8   bits per channel sample
//  IMG_W    256 input pixels per row (>= POOL)
//  POOL     2   window edge and stride (2..8)
//  CH       1   channels packed per beat; each is pooled independently
//  SIGNED   0   1 = two's-complement compare, 0 = unsigned
// PORTS
//  i_clk         in   1          clock, rising edge
//  i_reset_n     in   1          asynchronous active-low reset
//  i_sof         in   1          start of frame; qualified by i_data_valid, marks pixel (0,0)
//  i_data_valid  in   1          input beat valid
//  i_data        in   CH*DATA_W  input pixel, channel 0 in LSBs
//  o_data_valid  out  1          pooled output valid, one-cycle pulse per output pixel
//  o_data        out  CH*DATA_W  pooled pixel, same packing
//  o_row_done    out  1          pulse with the last output of each pooled row
// BEHAVIOUR
//  Reset (async assert, sync release): o_data_valid=0, o_data=0, o_row_done=0; counters=0; hacc cleared.
//   Line-buffer contents are undefined after reset; pool-row 0 always overwrites them.
//  Counters: col 0..IMG_W-1, prow 0..POOL-1, hcnt 0..POOL-1, ocol 0..OW-1, where OW=IMG_W/POOL (floor).
//   Counters advance only on i_data_valid. Gaps in valid stall the block without loss.
//  Horizontal: on each valid beat with col < OW*POOL, hacc = (hcnt==0) ? pixel : max(hacc,pixel), per channel.
//  Window column close (hcnt==POOL-1): m = max(hacc_next, lbuf[ocol]) if prow>0, else hacc_next.
//   If prow<POOL-1, write m to lbuf[ocol].
//   If prow==POOL-1, register m into o_data and pulse o_data_valid.
//  Latency: o_data_valid is asserted exactly 1 cycle after the beat carrying the window's bottom-right pixel.
//   o_data holds its value until the next output.
//  Tail columns: col >= OW*POOL are consumed but ignored (no hacc or lbuf update).
//  Row wrap: at col==IMG_W-1, col<=0, ocol<=0, hcnt<=0, and prow wraps POOL-1 -> 0.
//  o_row_done=1 together with o_data_valid when ocol==OW-1.
//  Compare: SIGNED=1 uses $signed per channel; a tie keeps the earlier value (results are bit-identical either way).
//  i_sof && i_data_valid: forces col=prow=hcnt=ocol=0 before the beat is processed, so that beat is pixel (0,0).
//   A partially accumulated window is discarded and no output is emitted for it. Mid-frame sof is legal.
//  No backpressure: downstream must accept every o_data_valid pulse. Max throughput is 1 input/cycle.
//  Reset mid-frame: all state is lost. The next frame must begin with i_sof or at a true row-0/col-0 boundary.
//  Line-buffer read and write of the same ocol occur in one cycle. A read-before-write behaviour is not required:
//   the read uses the registered value, the write goes to the same address, and there is no read-after-write hazard
//   because successive writes to an address are >= IMG_W beats apart.
// STRUCTURE
//  maxpool_pkg: function max_ch(a,b,signed_mode); localparams OW, COL_W=$clog2(IMG_W), OCOL_W=$clog2(OW),
//   PROW_W=$clog2(POOL); typedef of a packed pixel vector.
//  Sub-module maxpool_line_buf: OW x (CH*DATA_W) simple dual-port RAM, one write port, one async or registered-bypass
//   read port. It is inferred as LUTRAM or BRAM.
//  Top: counters, the per-channel compare lanes generated with a generate loop, and the output register.
// TESTING
//  1 Reset: DATA_W=8, IMG_W=4, POOL=2. Input rows [1,5,2,3], [4,0,9,7]
//     -> outputs 5 then 9; o_row_done is high with the 9; each pulse comes 1 cycle after the beat that completes it.
//  2 Odd width: IMG_W=5, POOL=2. Row0 [1,2,3,4,99], row1 [0,0,0,0,99]
//     -> outputs exactly 2 and 4; the 99 values never appear; exactly 2 output pulses.
//  3 Signed mode: SIGNED=1, POOL=2. Window {-3,-1,-8,-2} -> -1 (8'hFF). With SIGNED=0 the same bytes -> 8'hFF (255).
//  4 Multi-channel, POOL=3, CH=2, IMG_W=6. Channel-0 ramp 0..35 and channel 1 = 35-ch0
//     -> ch0 outputs 14,17,32,35; ch1 outputs 35,32,17,14, independently.
//  5 Valid gaps: repeat test 1 with i_data_valid randomly low 50% of cycles
//     -> identical output sequence; each output 1 cycle after its completing beat.
//  6 Resync: assert i_sof mid-row-1 of a frame, then stream a clean frame
//     -> no output from the aborted window; the new frame's outputs match a reference model. Also assert async
//     i_reset_n mid-frame -> all outputs are 0 immediately.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared helpers for the streaming max-pool: geometry functions and the
// per-channel compare used by every lane.
package maxpool_pkg;

  localparam int MAX_W = 32;
  typedef logic [MAX_W-1:0] samp_t;

  function automatic int unsigned out_cols(input int unsigned img_w, input int unsigned pool);
    return img_w / pool;
  endfunction

  // Index width that never collapses to zero bits for a one-entry range.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Flipping the sign bit turns two's complement into offset binary, so a
  // single unsigned compare serves both modes. A tie keeps a.
  function automatic samp_t max_ch(input samp_t a, input samp_t b,
                                   input logic signed_mode, input int unsigned w);
    samp_t bias;
    bias = signed_mode ? (samp_t'(1) << (w - 1)) : '0;
    return ((b ^ bias) > (a ^ bias)) ? b : a;
  endfunction

endpackage

// File: rtl/maxpool_line_buf.sv
// One pooled row of partial column maxima: one write port, asynchronous read.
module maxpool_line_buf #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8,
  parameter int AW    = 7
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/maxpool_stream.sv
// Streaming POOLxPOOL / stride-POOL max-pool over a raster feature map,
// one pixel per valid beat, CH channels pooled independently.
module maxpool_stream
  import maxpool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int POOL   = 2,
  parameter int CH     = 1,
  parameter int SIGNED = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_sof,
  input  logic                 i_data_valid,
  input  logic [CH*DATA_W-1:0] i_data,
  output logic                 o_data_valid,
  output logic [CH*DATA_W-1:0] o_data,
  output logic                 o_row_done
);

  localparam int OW     = out_cols(IMG_W, POOL);
  localparam int COL_W  = idx_w(IMG_W);
  localparam int OCOL_W = idx_w(OW);
  localparam int PROW_W = idx_w(POOL);
  localparam int PW     = CH * DATA_W;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [COL_W:0]    COL_END   = (COL_W + 1)'(OW * POOL);
  localparam logic [PROW_W-1:0] P_LAST    = PROW_W'(POOL - 1);
  localparam logic [OCOL_W-1:0] OCOL_LAST = OCOL_W'(OW - 1);
  localparam logic              SGN       = (SIGNED != 0);

  typedef logic [PW-1:0] pix_t;

  logic [COL_W-1:0]  col_q, col_d, col_e;
  logic [PROW_W-1:0] prow_q, prow_d, prow_e;
  logic [PROW_W-1:0] hcnt_q, hcnt_d, hcnt_e;
  logic [OCOL_W-1:0] ocol_q, ocol_d, ocol_e;
  pix_t              hacc_q, hacc_d, hacc_nx;
  pix_t              o_data_q, o_data_d;
  logic              valid_q, valid_d;
  logic              row_done_q, row_done_d;

  pix_t lb_rd, m_pix;
  logic lb_we, in_win, close;

  // A qualified sof makes the current beat pixel (0,0), abandoning any partial window.
  always_comb begin
    col_e  = i_sof ? '0 : col_q;
    prow_e = i_sof ? '0 : prow_q;
    hcnt_e = i_sof ? '0 : hcnt_q;
    ocol_e = i_sof ? '0 : ocol_q;
  end

  assign in_win = ({1'b0, col_e} < COL_END);
  assign close  = in_win && (hcnt_e == P_LAST);

  for (genvar c = 0; c < CH; c++) begin : g_lane
    logic [DATA_W-1:0] px, acc, lb, h, m;
    assign px  = i_data[c*DATA_W +: DATA_W];
    assign acc = hacc_q[c*DATA_W +: DATA_W];
    assign lb  = lb_rd[c*DATA_W +: DATA_W];
    assign h   = (hcnt_e == '0) ? px
               : DATA_W'(max_ch(samp_t'(acc), samp_t'(px), SGN, DATA_W));
    assign m   = (prow_e != '0) ? DATA_W'(max_ch(samp_t'(lb), samp_t'(h), SGN, DATA_W)) : h;
    assign hacc_nx[c*DATA_W +: DATA_W] = h;
    assign m_pix[c*DATA_W +: DATA_W]   = m;
  end

  maxpool_line_buf #(
    .DEPTH (OW),
    .WIDTH (PW),
    .AW    (OCOL_W)
  ) u_line_buf (
    .i_clk   (i_clk),
    .i_we    (lb_we),
    .i_waddr (ocol_e),
    .i_wdata (m_pix),
    .i_raddr (ocol_e),
    .o_rdata (lb_rd)
  );

  always_comb begin
    col_d      = col_q;
    prow_d     = prow_q;
    hcnt_d     = hcnt_q;
    ocol_d     = ocol_q;
    hacc_d     = hacc_q;
    o_data_d   = o_data_q;
    valid_d    = 1'b0;
    row_done_d = 1'b0;
    lb_we      = 1'b0;
    if (i_data_valid) begin
      if (in_win) begin
        hacc_d = hacc_nx;
        if (close) begin
          if (prow_e == P_LAST) begin
            o_data_d   = m_pix;
            valid_d    = 1'b1;
            row_done_d = (ocol_e == OCOL_LAST);
          end else begin
            lb_we = 1'b1;
          end
        end
      end
      if (col_e == COL_LAST) begin
        col_d  = '0;
        ocol_d = '0;
        hcnt_d = '0;
        prow_d = (prow_e == P_LAST) ? '0 : prow_e + 1'b1;
      end else begin
        col_d  = col_e + 1'b1;
        prow_d = prow_e;
        hcnt_d = hcnt_e;
        ocol_d = ocol_e;
        if (close) begin
          hcnt_d = '0;
          ocol_d = ocol_e + 1'b1;
        end else if (in_win) begin
          hcnt_d = hcnt_e + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      col_q      <= '0;
      prow_q     <= '0;
      hcnt_q     <= '0;
      ocol_q     <= '0;
      hacc_q     <= '0;
      o_data_q   <= '0;
      valid_q    <= 1'b0;
      row_done_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      prow_q     <= prow_d;
      hcnt_q     <= hcnt_d;
      ocol_q     <= ocol_d;
      hacc_q     <= hacc_d;
      o_data_q   <= o_data_d;
      valid_q    <= valid_d;
      row_done_q <= row_done_d;
    end
  end

  assign o_data_valid = valid_q;
  assign o_data       = o_data_q;
  assign o_row_done   = row_done_q;

endmodule
